pattern_ddr3_loader: RTL
========================

Name: pattern_ddr3_loader

Overview:
- Upstream producer for the pattern fetch/send stage, in the DDR3 EMIF clock domain.
- Accepts one pattern-set packet as a 256-bit streaming input: a header word followed by body words.
- Writes the packet linearly into DDR3 over the Avalon-MM EMIF write port.
- Manages the "pattern loaded" flag in on-chip memory word 0: clears it to 0 at packet start, sets it to 256'h55 after the final DDR3 write is accepted. The fetch stage polls this flag.

Parameters:
- ADDR_W, 22, DDR3 word-address width.
- MAX_WORDS, 22'h3FFFFF, maximum body words accepted (header word excluded).
- FLAG_VALUE, 256'h55, value written to on-chip word 0 on success.

Ports:
- ddr3_emif_clk  in  1  clock.
- ddr3_emif_rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat accepted when s_valid&&s_ready.
- s_data  in  256  beat data.
- s_sop  in  1  first beat (header).
- s_eop  in  1  last beat.
- ddr3_emif_ready  in  1  EMIF not-waitrequest.
- ddr3_emif_write  out  1  write request.
- ddr3_emif_addr  out  22  word address.
- ddr3_emif_write_data  out  256  write data.
- ddr3_emif_byte_enable  out  32  all ones when writing, else 0.
- ddr3_emif_burst_count  out  5  constant 1.
- onchip_mem_clken / onchip_mem_chip_select / onchip_mem_write  out  1  on-chip write strobes.
- onchip_mem_addr  out  11  always 0.
- onchip_mem_byte_enable  out  32  all ones during a write.
- onchip_mem_write_data  out  256  0 or FLAG_VALUE.
- busy  out  1  state != IDLE and != ERR.
- done  out  1  one-cycle pulse on flag set.
- error  out  1  sticky until next sop.
- err_code  out  2  0 none, 1 short packet, 2 long packet, 3 bad header.
- words_written  out  22  DDR3 writes accepted in current packet, header included.

Behaviour:
- Reset: all outputs 0 except ddr3_emif_burst_count=1. State IDLE.
- Header layout, MSB first, 32-bit fields: h_pix[255:224], v_pix[223:192], total_pix[191:160], pat_num[159:128], fill_size[127:96], start_addr[95:64], end_addr[63:32], rsv[31:0].
- Write holding register: one deep, with wr_pending.
  - wr_pending drives ddr3_emif_write.
  - addr, data and write are held stable while wr_pending && !ddr3_emif_ready.
  - A write completes on the cycle where ddr3_emif_write && ddr3_emif_ready; words_written increments on that cycle.
  - s_ready = (state in HDR/BODY) && (!wr_pending || ddr3_emif_ready), giving full throughput.
- IDLE:
  - s_valid && !s_sop: s_ready=1, beat discarded.
  - s_valid && s_sop: s_ready=0, go to CLR_FLAG.
- CLR_FLAG: one cycle on-chip write of 0 to addr 0 (clken, chip_select, write, byte_enable all asserted for one cycle). Clear error, err_code and words_written. Go to HDR.
- HDR:
  - Accept the sop beat. Load it into the holding register at addr 0. Latch total_pix and pat_num.
  - If s_eop is also set on this beat: err_code=1, go to ERR.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - per_pat = total_pix[31:8] + |total_pix[7:0] (24 bits).
  - expect = pat_num * per_pat, with a 56-bit product.
  - If expect==0 or expect>MAX_WORDS: err_code=3, go to ERR.
  - Otherwise body_left=expect[21:0], next addr=1, go to BODY.
- BODY:
  - Each accepted beat is loaded at the next addr; addr increments and body_left decrements.
  - s_eop with body_left>1: err_code=1, go to ERR.
  - body_left==1 beat without s_eop: err_code=2, go to ERR. ERR then discards stream beats until an eop beat is seen.
  - body_left==1 beat with s_eop: go to DRAIN.
  - s_sop arriving during BODY is treated as a data beat (no restart).
- DRAIN: wait for !wr_pending, then go to SET_FLAG.
- SET_FLAG: one cycle on-chip write of FLAG_VALUE to addr 0; pulse done; go to IDLE.
- ERR:
  - error=1. The pending write is completed (never abandoned mid-handshake).
  - The flag stays 0.
  - s_ready=1 only while discarding for err_code 2. Once that eop has been seen (or immediately for other codes), s_ready=0.
  - s_valid && s_sop: go to CLR_FLAG.
- Reset mid-operation: all state is lost and ddr3_emif_write drops immediately. The flag word is unchanged, so it reads 0 if reset occurs after CLR_FLAG.

Optional Feature:
- Macro LOADER_HDR_CHECK_EN.
- When defined, CALC additionally checks:
  - total_pix == h_pix*v_pix (low 32 bits);
  - end_addr == start_addr + expect.
  - Any mismatch gives err_code=3.
- When undefined, only the expect==0 / MAX_WORDS checks apply.

Decomposition:
- Shared package pattern_pkg holds:
  - header field bit positions (MSB/LSB localparams);
  - FLAG_VALUE constant 256'h55;
  - err_code encodings;
  - the state encoding enum. The fetch stage uses the same field constants.
- One sub-module, avmm_wr_hold: the one-deep write holding register with the ready/valid-to-waitrequest conversion.

Test Plan:
- Nominal: header total_pix=512, pat_num=2, followed by 4 body beats with eop on the 4th; ready held 1.
  - 5 DDR3 writes at addr 0..4.
  - On-chip write 0 first, then 256'h55.
  - done pulses once; words_written=5; no stall.
- Backpressure: same packet with ddr3_emif_ready toggled 1/0 pseudo-randomly.
  - Addr and data held stable while not ready; s_ready=0 only when holding and not ready.
  - Identical write contents to the nominal case.
- Tail rounding: total_pix=300, pat_num=3.
  - expect=6 body beats; eop on the 6th is accepted; flag set.
- Short packet: total_pix=512, pat_num=2, eop on body beat 2.
  - err_code=1, error=1; flag stays 0; done never pulses.
  - A following valid packet recovers.
- Long packet: same header, 6 body beats with eop on the 6th.
  - err_code=2 at beat 4; beats 5-6 discarded with s_ready=1; no DDR3 writes beyond addr 4.
- Bad header: pat_num=0, then separately total_pix=0.
  - err_code=3; only the header write to addr 0 occurs.
  - With LOADER_HDR_CHECK_EN: h=16, v=16, total_pix=257 also gives err_code=3.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared pattern-set definitions: header field positions, flag value, error codes, loader states.
package pattern_pkg;

    localparam int H_PIX_MSB     = 255;
    localparam int H_PIX_LSB     = 224;
    localparam int V_PIX_MSB     = 223;
    localparam int V_PIX_LSB     = 192;
    localparam int TOTAL_PIX_MSB = 191;
    localparam int TOTAL_PIX_LSB = 160;
    localparam int PAT_NUM_MSB   = 159;
    localparam int PAT_NUM_LSB   = 128;
    localparam int FILL_SIZE_MSB = 127;
    localparam int FILL_SIZE_LSB = 96;
    localparam int START_ADDR_MSB = 95;
    localparam int START_ADDR_LSB = 64;
    localparam int END_ADDR_MSB  = 63;
    localparam int END_ADDR_LSB  = 32;
    localparam int RSV_MSB       = 31;
    localparam int RSV_LSB       = 0;

    localparam logic [255:0] FLAG_VALUE = 256'h55;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_HDR   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_FLAG,
        ST_HDR,
        ST_CALC,
        ST_BODY,
        ST_DRAIN,
        ST_SET_FLAG,
        ST_ERR
    } state_t;

endpackage

// File: rtl/pattern_ddr3_loader_avmm_wr_hold.sv
// One-deep Avalon-MM write holding register (valid/ready in, waitrequest-style out).
// Latency: 1 cycle from accepted input to write request.
// Backpressure: in_rdy drops only while a write is held and the EMIF is not ready.
module avmm_wr_hold #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 256
) (
    input  logic              ddr3_emif_clk,
    input  logic              ddr3_emif_rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              emif_ready,
    output logic              wr_pend,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_dat,
    output logic              wr_done
);

    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    assign in_rdy  = !pend_q || emif_ready;
    assign wr_done = pend_q && emif_ready;
    assign wr_pend = pend_q;
    assign wr_addr = addr_q;
    assign wr_dat  = dat_q;

    // A new load in the completing cycle keeps the slot full.
    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (wr_done) begin
            pend_d = 1'b0;
        end
        if (in_vld && in_rdy) begin
            pend_d = 1'b1;
            addr_d = in_addr;
            dat_d  = in_dat;
        end
    end

    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            dat_q  <= dat_d;
        end
    end

endmodule

// File: rtl/pattern_ddr3_loader.sv
// Streams one pattern-set packet into DDR3 and manages the on-chip "loaded" flag word.
// Latency: header + 1 CALC cycle, then one DDR3 write per beat; flag set after the last write.
// Backpressure: s_ready follows the write holding register; optional LOADER_HDR_CHECK_EN adds header checks.
module pattern_ddr3_loader
    import pattern_pkg::*;
#(
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] MAX_WORDS  = 22'h3FFFFF,
    parameter logic [255:0]      FLAG_VALUE = pattern_pkg::FLAG_VALUE
) (
    input  logic              ddr3_emif_clk,
    input  logic              ddr3_emif_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [255:0]      s_data,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic              ddr3_emif_ready,
    output logic              ddr3_emif_write,
    output logic [ADDR_W-1:0] ddr3_emif_addr,
    output logic [255:0]      ddr3_emif_write_data,
    output logic [31:0]       ddr3_emif_byte_enable,
    output logic [4:0]        ddr3_emif_burst_count,
    output logic              onchip_mem_clken,
    output logic              onchip_mem_chip_select,
    output logic              onchip_mem_write,
    output logic [10:0]       onchip_mem_addr,
    output logic [31:0]       onchip_mem_byte_enable,
    output logic [255:0]      onchip_mem_write_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_written
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] left_q, left_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [31:0]       tot_q, tot_d;
    logic [31:0]       pat_q, pat_d;
    logic              error_q, error_d;
    logic              discard_q, discard_d;
    logic [1:0]        code_q, code_d;

    logic        hold_vld, hold_rdy, wr_pend, wr_done, hdr_load, hdr_ok, oc_wr;
    logic [23:0] per_pat;
    logic [55:0] exp_cnt;

    assign per_pat  = tot_q[31:8] + {23'b0, |tot_q[7:0]};
    assign exp_cnt  = 56'(pat_q) * 56'(per_pat);
    assign hold_vld = s_valid && s_ready && (state_q == ST_HDR || state_q == ST_BODY);
    assign hdr_load = hold_vld && (state_q == ST_HDR);

`ifdef LOADER_HDR_CHECK_EN
    logic [31:0] hp_q, hp_d, vp_q, vp_d, sa_q, sa_d, ea_q, ea_d;
    logic [31:0] hv_lo;

    assign hv_lo  = hp_q * vp_q;
    assign hdr_ok = (tot_q == hv_lo) && ({24'b0, ea_q} == ({24'b0, sa_q} + exp_cnt));

    always_comb begin
        hp_d = hp_q;
        vp_d = vp_q;
        sa_d = sa_q;
        ea_d = ea_q;
        if (hdr_load) begin
            hp_d = s_data[H_PIX_MSB:H_PIX_LSB];
            vp_d = s_data[V_PIX_MSB:V_PIX_LSB];
            sa_d = s_data[START_ADDR_MSB:START_ADDR_LSB];
            ea_d = s_data[END_ADDR_MSB:END_ADDR_LSB];
        end
    end

    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            hp_q <= '0;
            vp_q <= '0;
            sa_q <= '0;
            ea_q <= '0;
        end else begin
            hp_q <= hp_d;
            vp_q <= vp_d;
            sa_q <= sa_d;
            ea_q <= ea_d;
        end
    end
`else
    assign hdr_ok = 1'b1;
`endif

    // Sop beats are never consumed outside HDR so they can restart a packet.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE:         s_ready = s_valid && !s_sop;
            ST_HDR, ST_BODY: s_ready = hold_rdy;
            ST_ERR:          s_ready = discard_q && !s_sop;
            default:         s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        words_d   = words_q + ADDR_W'(wr_done);
        tot_d     = tot_q;
        pat_d     = pat_q;
        error_d   = error_q;
        discard_d = discard_q;
        code_d    = code_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid && s_sop) state_d = ST_CLR_FLAG;
            end
            ST_CLR_FLAG: begin
                error_d   = 1'b0;
                code_d    = ERR_NONE;
                words_d   = '0;
                addr_d    = '0;
                discard_d = 1'b0;
                state_d   = ST_HDR;
            end
            ST_HDR: begin
                if (hdr_load) begin
                    tot_d  = s_data[TOTAL_PIX_MSB:TOTAL_PIX_LSB];
                    pat_d  = s_data[PAT_NUM_MSB:PAT_NUM_LSB];
                    addr_d = addr_q + ADDR_W'(1);
                    if (s_eop) begin
                        code_d  = ERR_SHORT;
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (exp_cnt == '0 || exp_cnt > 56'(MAX_WORDS) || !hdr_ok) begin
                    code_d  = ERR_HDR;
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    left_d  = exp_cnt[ADDR_W-1:0];
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (hold_vld) begin
                    addr_d = addr_q + ADDR_W'(1);
                    left_d = left_q - ADDR_W'(1);
                    if (left_q == ADDR_W'(1)) begin
                        if (s_eop) begin
                            state_d = ST_DRAIN;
                        end else begin
                            code_d    = ERR_LONG;
                            error_d   = 1'b1;
                            discard_d = 1'b1;
                            state_d   = ST_ERR;
                        end
                    end else if (s_eop) begin
                        code_d  = ERR_SHORT;
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DRAIN: begin
                if (!wr_pend) state_d = ST_SET_FLAG;
            end
            ST_SET_FLAG: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (s_valid && s_ready && s_eop) discard_d = 1'b0;
                if (s_valid && s_sop) state_d = ST_CLR_FLAG;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            words_q   <= '0;
            tot_q     <= '0;
            pat_q     <= '0;
            error_q   <= 1'b0;
            discard_q <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            words_q   <= words_d;
            tot_q     <= tot_d;
            pat_q     <= pat_d;
            error_q   <= error_d;
            discard_q <= discard_d;
            code_q    <= code_d;
        end
    end

    avmm_wr_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (256)
    ) u_hold (
        .ddr3_emif_clk   (ddr3_emif_clk),
        .ddr3_emif_rst_n (ddr3_emif_rst_n),
        .in_vld          (hold_vld),
        .in_rdy          (hold_rdy),
        .in_addr         (addr_q),
        .in_dat          (s_data),
        .emif_ready      (ddr3_emif_ready),
        .wr_pend         (wr_pend),
        .wr_addr         (ddr3_emif_addr),
        .wr_dat          (ddr3_emif_write_data),
        .wr_done         (wr_done)
    );

    assign oc_wr                  = (state_q == ST_CLR_FLAG) || (state_q == ST_SET_FLAG);
    assign onchip_mem_clken       = oc_wr;
    assign onchip_mem_chip_select = oc_wr;
    assign onchip_mem_write       = oc_wr;
    assign onchip_mem_addr        = '0;
    assign onchip_mem_byte_enable = {32{oc_wr}};
    assign onchip_mem_write_data  = (state_q == ST_SET_FLAG) ? FLAG_VALUE : '0;

    assign ddr3_emif_write       = wr_pend;
    assign ddr3_emif_byte_enable = {32{wr_pend}};
    assign ddr3_emif_burst_count = 5'd1;

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign done          = (state_q == ST_SET_FLAG);
    assign error         = error_q;
    assign err_code      = code_q;
    assign words_written = words_q;

endmodule
